fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction-fetch front end between the program counter and decode.
- Issues instruction-memory requests at the current PC and tells the PC when a request was accepted so it can advance.
- Pairs each in-order memory response with its PC and buffers {instr, pc} in a small FIFO toward decode.
- On redirect (branch/jump), discards buffered entries and in-flight responses.

Parameters:
- XLEN, 32, address/instruction width.
- DEPTH, 2, maximum in-flight requests plus buffered entries (power of 2, >=2).
- NOP_INSTR, 32'h00000013, value driven on id_instr when no valid entry exists.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- pc_addr  in  XLEN  current PC value to fetch.
- redirect  in  1  flush request; PC is loading a new target this cycle.
- pc_advance  out  1  request accepted this cycle; PC may increment by 4.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; equals pc_addr.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid; responses return in request order.
- imem_rdata  in  XLEN  instruction word.
- id_valid  out  1  decode-side entry valid.
- id_instr  out  XLEN  head instruction, or NOP_INSTR when empty.
- id_pc  out  XLEN  PC of head instruction, or 0 when empty.
- id_ready  in  1  decode consumes the head this cycle.

Behaviour:
- Reset (async, rst=0):
  - imem_req=0, pc_advance=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0.
  - Outstanding count, kill count, PC queue and data FIFO all cleared.
  - Reset mid-transfer drops everything; no response arriving after reset release is written.
- Credit rule: imem_req=1 iff (outstanding + data_count) < DEPTH and redirect=0. Outputs are combinational from registered counters plus redirect.
- Accept: when imem_req && imem_gnt:
  - pc_advance=1 in the same cycle (combinational).
  - pc_addr is pushed into the PC queue.
  - outstanding increments.
- Response: when imem_rvalid:
  - If kill>0, decrement kill; data is discarded.
  - Otherwise pop the PC queue and write {imem_rdata, popped pc} into the data FIFO; outstanding decrements.
  - The write is visible on id_* the next cycle.
- Minimum latency: grant at T, rvalid at T+1, id_valid at T+2.
- Decode handshake: the head pops when id_valid && id_ready. id_* holds stable while id_valid && !id_ready.
- Simultaneous events:
  - Accept, response and pop in the same cycle are all legal. Counters are updated with net deltas (+1 accept, -1 response, +1/-1 FIFO).
  - FIFO write and pop in the same cycle at full occupancy are legal.
- Redirect (cycle R):
  - imem_req=0 and pc_advance=0 in cycle R.
  - Data FIFO and PC queue are cleared at the end of R, so id_valid=0 at R+1.
  - kill is set to the outstanding count minus the number of responses arriving in R. Any rvalid arriving in cycle R is itself discarded.
  - outstanding is set to that same kill value.
  - Requests resume at R+1 at the new pc_addr, subject to credit. Kill responses still consume credit until they drain.
- Back-to-back redirects: kill is recomputed each time from current outstanding; it never accumulates past DEPTH.
- Protocol violation: imem_rvalid with outstanding==0 and kill==0 is ignored; no state change.
- Width rules:
  - Counters are $clog2(DEPTH)+1 bits.
  - FIFO pointers wrap modulo DEPTH.
  - imem_addr passes pc_addr unmodified.

Decomposition:
- Package fetch_pkg holds XLEN, NOP_INSTR, the DEPTH-derived pointer/counter width function, and the packed {instr, pc} entry typedef.
- One sub-module, sync_fifo_reg: parameterised width/depth register FIFO with synchronous clear and async active-low reset. Instantiated twice: PC queue (XLEN wide) and data FIFO (2*XLEN wide).

Test Plan:
- Reset release, imem_gnt=1, rvalid one cycle after each grant, id_ready=1, pc_addr stepping 0,4,8:
  - id_valid rises at cycle 2 with id_pc=0, id_instr=rdata0.
  - pc_advance every cycle once steady.
  - No bubbles after fill.
- id_ready=0 with DEPTH=2:
  - After two grants, imem_req drops.
  - id_instr/id_pc stay stable on the head (pc 0).
  - Raising id_ready restores one request per popped entry.
- imem_gnt held 0 for 3 cycles: imem_req stays 1, imem_addr=pc_addr, pc_advance=0, no entries created.
- Redirect with 2 outstanding:
  - The next two rvalid words (e.g. 32'hDEADBEEF) never appear on id_*.
  - First visible entry carries id_pc = new target 0x100.
- Redirect in the same cycle as rvalid plus 1 outstanding: only one later response is killed; the following response is delivered with the correct PC.
- Spurious imem_rvalid with nothing outstanding: id_valid stays 0 and counters are unchanged. Async rst asserted mid-stream clears all outputs to reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the datapath width, bubble instruction and FIFO entry layout.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

endpackage

// File: rtl/sync_fifo_reg.sv
// Small register-based FIFO with synchronous clear.
// Head word is presented combinationally on dout.
module sync_fifo_reg
    import fetch_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      push,
    input  logic [W-1:0]              din,
    input  logic                      pop,
    output logic [W-1:0]              dout,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < FULL) || do_pop);
    assign dout    = mem[rptr];

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clr) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: issues imem requests under a credit
// limit, pairs in-order responses with their PC, buffers for decode.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            redirect,
    output logic            pc_advance,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready
);

    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   kill;
    logic [CW-1:0]   data_count;
    logic [CW-1:0]   pcq_count;
    logic [XLEN-1:0] pcq_head;
    logic [CW:0]     occupancy;
    logic            credit;
    logic            accept;
    logic            resp_ok;
    logic            live;
    logic            pop_id;
    logic [CW-1:0]   remaining;
    entry_t          wr_entry;
    entry_t          head;

    // In-flight responses (live or killed) still hold credit.
    assign occupancy = {1'b0, outstanding} + {1'b0, data_count};
    assign credit    = occupancy < LIMIT;

    assign imem_req   = rst && credit && !redirect;
    assign imem_addr  = pc_addr;
    assign accept     = imem_req && imem_gnt;
    assign pc_advance = accept;

    // A response with nothing outstanding is a protocol error: ignored.
    assign resp_ok   = imem_rvalid && (outstanding != '0);
    assign remaining = outstanding - CW'(resp_ok);
    assign live      = imem_rvalid && (kill == '0)
                       && (pcq_count != '0) && !redirect;

    assign pop_id = id_valid && id_ready;

    assign wr_entry.instr = imem_rdata;
    assign wr_entry.pc    = pcq_head;

    // Outstanding/kill bookkeeping; redirect turns every survivor into a kill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            kill        <= '0;
        end else if (redirect) begin
            outstanding <= remaining;
            kill        <= remaining;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(resp_ok);
            if (resp_ok && (kill != '0)) begin
                kill <= kill - 1'b1;
            end
        end
    end

    sync_fifo_reg #(
        .W     (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (accept),
        .din   (pc_addr),
        .pop   (live),
        .dout  (pcq_head),
        .count (pcq_count)
    );

    sync_fifo_reg #(
        .W     (2*XLEN),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (live),
        .din   (wr_entry),
        .pop   (pop_id),
        .dout  (head),
        .count (data_count)
    );

    // Decode view of the head entry; bubble values when empty.
    always_comb begin
        id_valid = (data_count != '0);
        id_instr = NOP_INSTR;
        id_pc    = '0;
        if (id_valid) begin
            id_instr = head.instr;
            id_pc    = head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios then random
// traffic, all checked against a queue-based transaction model.
module tb_fetch_buffer;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc_addr;
    logic        redirect;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .redirect    (redirect),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          killed;
    } flight_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    flight_t     infl[$];
    ent_t        buff[$];
    logic [31:0] tb_pc;
    int          vectors;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit pending();
        return infl.size() > 0;
    endfunction

    // One clock of stimulus: drive, compare against model, advance model.
    task automatic step(input bit gnt, input bit rv, input logic [31:0] rd,
                        input bit redir, input bit rdy,
                        input logic [31:0] tgt);
        bit      exp_req;
        flight_t f;
        ent_t    e;
        @(negedge clk);
        pc_addr     = tb_pc;
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        redirect    = redir;
        id_ready    = rdy;
        #1;
        exp_req = (infl.size() + buff.size() < DEPTH) && !redir;
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        chk("pc_advance", {31'b0, pc_advance}, {31'b0, exp_req && gnt});
        chk("imem_addr", imem_addr, tb_pc);
        chk("id_valid", {31'b0, id_valid}, {31'b0, buff.size() > 0});
        chk("id_pc", id_pc, buff.size() > 0 ? buff[0].pc : 32'h0);
        chk("id_instr", id_instr, buff.size() > 0 ? buff[0].instr : NOP);
        @(posedge clk);
        if (redir) begin
            if (rv && infl.size() > 0) void'(infl.pop_front());
            foreach (infl[i]) infl[i].killed = 1'b1;
            buff.delete();
            tb_pc = tgt;
        end else begin
            if (rdy && buff.size() > 0) void'(buff.pop_front());
            if (rv && infl.size() > 0) begin
                f = infl.pop_front();
                if (!f.killed) begin
                    e.instr = rd;
                    e.pc    = f.pc;
                    buff.push_back(e);
                end
            end
            if (exp_req && gnt) begin
                f.pc     = tb_pc;
                f.killed = 1'b0;
                infl.push_back(f);
                tb_pc = tb_pc + 32'd4;
            end
        end
    endtask

    // Reset asserted between edges; outputs must clear immediately.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_adv", {31'b0, pc_advance}, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_pc", id_pc, 32'h0);
        infl.delete();
        buff.delete();
        tb_pc = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        errors      = 0;
        tb_pc       = 32'h0;
        rst         = 1'b0;
        pc_addr     = 32'h0;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        #3;
        chk("reset_req", {31'b0, imem_req}, 32'h0);
        chk("reset_adv", {31'b0, pc_advance}, 32'h0);
        chk("reset_valid", {31'b0, id_valid}, 32'h0);
        chk("reset_instr", id_instr, NOP);
        chk("reset_pc", id_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Streaming fill: grant always, response one cycle after grant.
        for (int k = 0; k < 8; k++)
            step(1'b1, pending(), 32'h1000_0000 + k, 1'b0, 1'b1, 32'h0);

        // Decode stalled: credit runs out, head holds.
        for (int k = 0; k < 6; k++)
            step(1'b1, pending(), 32'h1100_0000 + k, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++)
            step(1'b1, pending(), 32'h1200_0000 + k, 1'b0, 1'b1, 32'h0);

        // Memory refuses grants, then drain.
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 4; k++)
            step(1'b0, pending(), 32'h1300_0000 + k, 1'b0, 1'b1, 32'h0);

        // Redirect with two requests in flight.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 5; k++)
            step(1'b1, pending(), 32'h2000_0000 + k, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 4; k++)
            step(1'b0, pending(), 32'h2100_0000 + k, 1'b0, 1'b1, 32'h0);

        // Redirect coinciding with a response, one more in flight.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h3000_0000, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);

        // Spurious responses with nothing outstanding.
        step(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);

        // Random traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            bit rv;
            if (i == 1500) mid_reset();
            rv = pending() ? ($urandom % 3 != 0) : ($urandom % 16 == 0);
            step($urandom % 4 != 0, rv, $urandom, $urandom % 10 == 0,
                 $urandom % 4 != 0, $urandom & 32'hFFFF_FFFC);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
